// File: rtl/trig_source_sched.sv
// trig_source_sched: arbitrates external, periodic and software trigger
// sources ahead of the APV trigger generator. It shapes TRIG_CMD/RESET_CMD
// pulses, enforces dead time and reset guard time, and keeps saturating
// accepted/rejected trigger statistics.
// Optional build macro TRIG_TIMESTAMP_EN adds a 48-bit time base plus the
// TRIG_TIME/TIME_VALID outputs.
module trig_source_sched #(
  parameter int PULSE_W = 4,
  parameter int CNT_W   = 32
) (
  input  logic             CLK,
  input  logic             RSTb,
  input  logic [2:0]       SRC_EN,
  input  logic             EXT_TRIG,
  input  logic             SW_TRIG,
  input  logic             SW_RESET,
  input  logic [23:0]      PERIOD,
  input  logic [15:0]      DEAD_TIME,
  input  logic [7:0]       RESET_GUARD,
  input  logic             CLR_CNT,
  output logic             TRIG_CMD,
  output logic             RESET_CMD,
  output logic             BUSY,
  output logic [1:0]       LAST_SRC,
  output logic [CNT_W-1:0] ACCEPTED_CNT,
  output logic [CNT_W-1:0] REJECTED_CNT
`ifdef TRIG_TIMESTAMP_EN
  ,
  output logic [47:0]      TRIG_TIME,
  output logic             TIME_VALID
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TRIG   = 3'd1,
    S_HOLD   = 3'd2,
    S_RST    = 3'd3,
    S_RGUARD = 3'd4
  } state_t;

  // Add 0..3 to a statistics counter, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] val,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, val} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  state_t      state;
  logic [15:0] tcnt;
  logic        rst_pend;

  logic        ext_p0, ext_p1, ext_p2;
  logic        ext_req;

  logic [23:0] per_cnt;
  logic        per_on;
  logic        per_req;

  logic [2:0]  qual;
  logic [1:0]  n_req;
  logic [1:0]  n_rej;
  logic        go_rst;
  logic        accept;
  logic [1:0]  win_src;
  logic [15:0] dead_lim;
  logic [15:0] guard_lim;
  logic        pulse_last;
  logic        hold_done;
  logic        guard_done;

  // EXT_TRIG crosses into CLK through two flops; the third flop forms the
  // rising-edge detector and ext_req is registered from it.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      ext_p0  <= 1'b0;
      ext_p1  <= 1'b0;
      ext_p2  <= 1'b0;
      ext_req <= 1'b0;
    end else begin
      ext_p0  <= EXT_TRIG;
      ext_p1  <= ext_p0;
      ext_p2  <= ext_p1;
      ext_req <= ext_p1 & ~ext_p2;
    end
  end

  // The >= compare makes a lowered PERIOD fire at once instead of
  // running the counter all the way round.
  assign per_on  = SRC_EN[1] && (PERIOD != 24'd0);
  assign per_req = per_on && (per_cnt >= (PERIOD - 24'd1));

  // Periodic source counter: 0..PERIOD-1, parked at 0 while disabled.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      per_cnt <= 24'd0;
    end else if (!per_on || per_req) begin
      per_cnt <= 24'd0;
    end else begin
      per_cnt <= per_cnt + 24'd1;
    end
  end

  // Request qualification, arbitration and holdoff limits.
  always_comb begin
    qual       = {SW_TRIG & SRC_EN[2], per_req & SRC_EN[1], ext_req & SRC_EN[0]};
    n_req      = {1'b0, qual[0]} + {1'b0, qual[1]} + {1'b0, qual[2]};
    go_rst     = (state == S_IDLE) && rst_pend;
    accept     = (state == S_IDLE) && !rst_pend && (qual != 3'b000);
    n_rej      = n_req - {1'b0, accept};
    win_src    = 2'd2;
    if (qual[0]) begin
      win_src = 2'd0;
    end else if (qual[1]) begin
      win_src = 2'd1;
    end
    // A zero holdoff still gives one low cycle so the generator sees an edge.
    dead_lim   = (DEAD_TIME == 16'd0) ? 16'd1 : DEAD_TIME;
    guard_lim  = (RESET_GUARD == 8'd0) ? 16'd1 : {8'd0, RESET_GUARD};
    pulse_last = (tcnt == 16'(PULSE_W - 1));
    hold_done  = (({1'b0, tcnt} + 17'd1) >= {1'b0, dead_lim});
    guard_done = (({1'b0, tcnt} + 17'd1) >= {1'b0, guard_lim});
  end

  // SW_RESET is remembered in any state and consumed on entry to RST.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      rst_pend <= 1'b0;
    end else if (SW_RESET) begin
      rst_pend <= 1'b1;
    end else if (go_rst) begin
      rst_pend <= 1'b0;
    end
  end

  // Command FSM with registered TRIG_CMD/RESET_CMD/BUSY/LAST_SRC.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      state     <= S_IDLE;
      tcnt      <= 16'd0;
      TRIG_CMD  <= 1'b0;
      RESET_CMD <= 1'b0;
      BUSY      <= 1'b0;
      LAST_SRC  <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          tcnt <= 16'd0;
          if (go_rst) begin
            state     <= S_RST;
            RESET_CMD <= 1'b1;
            BUSY      <= 1'b1;
          end else if (accept) begin
            state    <= S_TRIG;
            TRIG_CMD <= 1'b1;
            BUSY     <= 1'b1;
            LAST_SRC <= win_src;
          end
        end
        S_TRIG: begin
          if (pulse_last) begin
            state    <= S_HOLD;
            TRIG_CMD <= 1'b0;
            tcnt     <= 16'd0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_HOLD: begin
          if (hold_done) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
            tcnt  <= 16'd0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_RST: begin
          if (pulse_last) begin
            state     <= S_RGUARD;
            RESET_CMD <= 1'b0;
            tcnt      <= 16'd0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        S_RGUARD: begin
          if (guard_done) begin
            state <= S_IDLE;
            BUSY  <= 1'b0;
            tcnt  <= 16'd0;
          end else begin
            tcnt <= tcnt + 16'd1;
          end
        end
        default: begin
          state     <= S_IDLE;
          tcnt      <= 16'd0;
          TRIG_CMD  <= 1'b0;
          RESET_CMD <= 1'b0;
          BUSY      <= 1'b0;
        end
      endcase
    end
  end

  // Statistics counters; a clear beats a same-cycle increment.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      ACCEPTED_CNT <= '0;
      REJECTED_CNT <= '0;
    end else if (CLR_CNT) begin
      ACCEPTED_CNT <= '0;
      REJECTED_CNT <= '0;
    end else begin
      ACCEPTED_CNT <= sat_add(ACCEPTED_CNT, {1'b0, accept});
      REJECTED_CNT <= sat_add(REJECTED_CNT, n_rej);
    end
  end

`ifdef TRIG_TIMESTAMP_EN
  logic [47:0] timestamp;

  // Free-running time base, captured in the accept cycle so TRIG_TIME and
  // TIME_VALID line up with the first high cycle of TRIG_CMD.
  always_ff @(posedge CLK or negedge RSTb) begin
    if (!RSTb) begin
      timestamp  <= 48'd0;
      TRIG_TIME  <= 48'd0;
      TIME_VALID <= 1'b0;
    end else begin
      timestamp  <= timestamp + 48'd1;
      TIME_VALID <= accept;
      if (accept) begin
        TRIG_TIME <= timestamp;
      end
    end
  end
`endif

endmodule

// File: tb/tb_trig_source_sched.sv
// Testbench for trig_source_sched: directed scenarios plus randomized
// traffic, compared every cycle against a window-based reference model.
module tb_trig_source_sched;

  localparam int PW = 4;
  localparam int CW = 8;
  localparam int SAT = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RSTb = 1'b0;
  logic [2:0]    SRC_EN = 3'd0;
  logic          EXT_TRIG = 1'b0;
  logic          SW_TRIG = 1'b0;
  logic          SW_RESET = 1'b0;
  logic [23:0]   PERIOD = 24'd0;
  logic [15:0]   DEAD_TIME = 16'd10;
  logic [7:0]    RESET_GUARD = 8'd20;
  logic          CLR_CNT = 1'b0;
  logic          TRIG_CMD;
  logic          RESET_CMD;
  logic          BUSY;
  logic [1:0]    LAST_SRC;
  logic [CW-1:0] ACCEPTED_CNT;
  logic [CW-1:0] REJECTED_CNT;

  trig_source_sched #(.PULSE_W(PW), .CNT_W(CW)) dut (
    .CLK(CLK), .RSTb(RSTb), .SRC_EN(SRC_EN), .EXT_TRIG(EXT_TRIG),
    .SW_TRIG(SW_TRIG), .SW_RESET(SW_RESET), .PERIOD(PERIOD),
    .DEAD_TIME(DEAD_TIME), .RESET_GUARD(RESET_GUARD), .CLR_CNT(CLR_CNT),
    .TRIG_CMD(TRIG_CMD), .RESET_CMD(RESET_CMD), .BUSY(BUSY),
    .LAST_SRC(LAST_SRC), .ACCEPTED_CNT(ACCEPTED_CNT), .REJECTED_CNT(REJECTED_CNT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // configuration applied at the start of the next driven cycle
  logic [2:0]  n_src = 3'd0;
  logic [23:0] n_per = 24'd0;
  logic [15:0] n_dt = 16'd10;
  logic [7:0]  n_rg = 8'd20;

  // reference model: command/busy windows in absolute cycle numbers
  int cyc = 0;
  int trig_lo, trig_hi, rst_lo, rst_hi, busy_lo, busy_hi;
  bit pend_m;
  int last_m, acc_m, rej_m, per_m;
  bit [3:0] ext_h;

  // observation helpers
  int trig_rises, rst_rises;
  bit prev_trig, prev_rst;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic bit in_win(input int lo, input int hi);
    return (cyc >= lo) && (cyc <= hi);
  endfunction

  function automatic int sat(input int v);
    return (v > SAT) ? SAT : v;
  endfunction

  task automatic model_reset();
    trig_lo = 0; trig_hi = -1;
    rst_lo = 0;  rst_hi = -1;
    busy_lo = 0; busy_hi = -1;
    pend_m = 1'b0;
    last_m = 0; acc_m = 0; rej_m = 0; per_m = 0;
    ext_h = 4'd0;
  endtask

  task automatic check_outputs();
    chk_eq($sformatf("trig_cmd@%0d", cyc), 64'(TRIG_CMD), 64'(in_win(trig_lo, trig_hi)));
    chk_eq($sformatf("reset_cmd@%0d", cyc), 64'(RESET_CMD), 64'(in_win(rst_lo, rst_hi)));
    chk_eq($sformatf("busy@%0d", cyc), 64'(BUSY), 64'(in_win(busy_lo, busy_hi)));
    chk_eq($sformatf("last_src@%0d", cyc), 64'(LAST_SRC), 64'(last_m));
    chk_eq($sformatf("acc_cnt@%0d", cyc), 64'(ACCEPTED_CNT), 64'(acc_m));
    chk_eq($sformatf("rej_cnt@%0d", cyc), 64'(REJECTED_CNT), 64'(rej_m));
  endtask

  // Apply the scheduling rules to the inputs of the current cycle.
  task automatic model_step();
    bit ereq, pon, preq, idle, enter;
    bit [2:0] q;
    int nq, dl, gl;
    ereq = ext_h[2] & ~ext_h[3];
    pon  = SRC_EN[1] && (PERIOD != 24'd0);
    preq = pon && (per_m >= int'(PERIOD) - 1);
    per_m = (!pon || preq) ? 0 : per_m + 1;
    q  = {SW_TRIG & SRC_EN[2], preq & SRC_EN[1], ereq & SRC_EN[0]};
    nq = int'(q[0]) + int'(q[1]) + int'(q[2]);
    idle  = !in_win(busy_lo, busy_hi);
    enter = idle && pend_m;
    dl = (DEAD_TIME == 16'd0) ? 1 : int'(DEAD_TIME);
    gl = (RESET_GUARD == 8'd0) ? 1 : int'(RESET_GUARD);
    if (enter) begin
      rst_lo = cyc + 1; rst_hi = cyc + PW;
      busy_lo = cyc + 1; busy_hi = cyc + PW + gl;
      rej_m = sat(rej_m + nq);
    end else if (idle && nq > 0) begin
      last_m = q[0] ? 0 : (q[1] ? 1 : 2);
      trig_lo = cyc + 1; trig_hi = cyc + PW;
      busy_lo = cyc + 1; busy_hi = cyc + PW + dl;
      acc_m = sat(acc_m + 1);
      rej_m = sat(rej_m + nq - 1);
    end else begin
      rej_m = sat(rej_m + nq);
    end
    pend_m = SW_RESET | (pend_m & !enter);
    if (CLR_CNT) begin
      acc_m = 0;
      rej_m = 0;
    end
    ext_h = {ext_h[2:0], EXT_TRIG};
    cyc++;
  endtask

  // One clock cycle: drive, check against the model, advance the model.
  task automatic step(input bit ext, input bit swt, input bit swr, input bit clr);
    @(posedge CLK);
    #1;
    SRC_EN = n_src; PERIOD = n_per; DEAD_TIME = n_dt; RESET_GUARD = n_rg;
    EXT_TRIG = ext; SW_TRIG = swt; SW_RESET = swr; CLR_CNT = clr;
    @(negedge CLK);
    check_outputs();
    model_step();
    if (TRIG_CMD && !prev_trig) trig_rises++;
    if (RESET_CMD && !prev_rst) rst_rises++;
    prev_trig = TRIG_CMD;
    prev_rst = RESET_CMD;
  endtask

  // One-cycle asynchronous reset, checking that outputs clear at once.
  task automatic do_reset();
    @(posedge CLK);
    #1;
    EXT_TRIG = 1'b0; SW_TRIG = 1'b0; SW_RESET = 1'b0; CLR_CNT = 1'b0;
    RSTb = 1'b0;
    #2;
    chk_eq("rst_trig_cmd", 64'(TRIG_CMD), 64'd0);
    chk_eq("rst_reset_cmd", 64'(RESET_CMD), 64'd0);
    chk_eq("rst_busy", 64'(BUSY), 64'd0);
    chk_eq("rst_acc_cnt", 64'(ACCEPTED_CNT), 64'd0);
    chk_eq("rst_rej_cnt", 64'(REJECTED_CNT), 64'd0);
    chk_eq("rst_last_src", 64'(LAST_SRC), 64'd0);
    @(posedge CLK);
    #1;
    RSTb = 1'b1;
    model_reset();
    @(negedge CLK);
    check_outputs();
    model_step();
    prev_trig = TRIG_CMD;
    prev_rst = RESET_CMD;
  endtask

  task automatic drain(input int n);
    n_src = 3'd0;
    n_per = 24'd0;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    int last_rise, width, busy_low, rst_w, guard_busy, first_rst, first_trig, hi_cnt;
    model_reset();
    do_reset();

    // 1: periodic source alone
    n_src = 3'b010; n_per = 24'd100; n_dt = 16'd10;
    trig_rises = 0; last_rise = -1; width = 0;
    for (int k = 0; k < 1010; k++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0);
      if (TRIG_CMD) width++;
      if (TRIG_CMD && width == 1) begin
        if (last_rise >= 0) chk_eq("t1_gap", 64'(k - last_rise), 64'd100);
        last_rise = k;
      end
      if (!TRIG_CMD && width != 0) begin
        chk_eq("t1_width", 64'(width), 64'(PW));
        width = 0;
      end
    end
    chk_eq("t1_pulses", 64'(trig_rises), 64'd10);
    chk_eq("t1_acc", 64'(ACCEPTED_CNT), 64'd10);
    chk_eq("t1_rej", 64'(REJECTED_CNT), 64'd0);
    drain(20);

    // 2: ext and software in the same idle cycle
    n_src = 3'b111; n_per = 24'd0;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    trig_rises = 0;
    for (int k = 0; k < 25; k++) step(k == 0, k == 3, 1'b0, 1'b0);
    chk_eq("t2_pulses", 64'(trig_rises), 64'd1);
    chk_eq("t2_last_src", 64'(LAST_SRC), 64'd0);
    chk_eq("t2_acc", 64'(ACCEPTED_CNT), 64'd1);
    chk_eq("t2_rej", 64'(REJECTED_CNT), 64'd1);
    drain(10);

    // 3: software trigger during dead time
    n_src = 3'b100; n_dt = 16'd10;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    trig_rises = 0; busy_low = 0;
    for (int k = 0; k < 30; k++) begin
      step(1'b0, k == 0 || k == 7, 1'b0, 1'b0);
      if (k >= 5 && BUSY && !TRIG_CMD) busy_low++;
    end
    chk_eq("t3_pulses", 64'(trig_rises), 64'd1);
    chk_eq("t3_rej", 64'(REJECTED_CNT), 64'd1);
    chk_eq("t3_dead_busy", 64'(busy_low), 64'd10);

    // 4: reset request during a trigger, guard time 20
    n_rg = 8'd20;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    trig_rises = 0; rst_rises = 0; rst_w = 0; guard_busy = 0; first_rst = -1;
    for (int k = 0; k < 60; k++) begin
      step(1'b0, k == 0 || k == 29 || k == 41, k == 2, 1'b0);
      if (RESET_CMD) begin
        rst_w++;
        if (first_rst < 0) first_rst = k;
      end
      if (k >= 16 && k <= 41 && BUSY && !RESET_CMD && !TRIG_CMD) guard_busy++;
    end
    chk_eq("t4_rst_start", 64'(first_rst), 64'd16);
    chk_eq("t4_rst_width", 64'(rst_w), 64'(PW));
    chk_eq("t4_guard_busy", 64'(guard_busy), 64'd20);
    chk_eq("t4_pulses", 64'(trig_rises), 64'd2);
    chk_eq("t4_acc", 64'(ACCEPTED_CNT), 64'd2);
    chk_eq("t4_rej", 64'(REJECTED_CNT), 64'd1);
    chk_eq("t4_last_src", 64'(LAST_SRC), 64'd2);

    // 5: external trigger latency and a second rise before TRIG_CMD
    n_src = 3'b001;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    first_trig = -1; hi_cnt = 0;
    for (int k = 0; k < 30; k++) begin
      step(k == 0 || k == 3, 1'b0, 1'b0, 1'b0);
      if (TRIG_CMD) begin
        hi_cnt++;
        if (first_trig < 0) first_trig = k;
      end
    end
    chk_eq("t5_first_high", 64'(first_trig), 64'd4);
    chk_eq("t5_high_cycles", 64'(hi_cnt), 64'(PW));
    chk_eq("t5_acc", 64'(ACCEPTED_CNT), 64'd1);
    chk_eq("t5_rej", 64'(REJECTED_CNT), 64'd1);

    // 6: reset mid-trigger with counters at 5, then clear in an accept cycle
    n_src = 3'b100;
    step(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 19; k++) step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_eq("t6_acc5", 64'(ACCEPTED_CNT), 64'd5);
    chk_eq("t6_trig_high", 64'(TRIG_CMD), 64'd1);
    do_reset();
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    chk_eq("t6_clr_acc", 64'(ACCEPTED_CNT), 64'd0);
    chk_eq("t6_clr_trig", 64'(TRIG_CMD), 64'd1);
    drain(20);

    // randomized traffic against the model
    for (int p = 0; p < 8; p++) begin
      n_src = 3'($urandom_range(0, 7));
      n_per = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 60));
      n_dt  = 16'($urandom_range(0, 20));
      n_rg  = 8'($urandom_range(0, 20));
      for (int k = 0; k < 500; k++) begin
        if ($urandom_range(0, 400) == 0) do_reset();
        else step($urandom_range(0, 6) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 60) == 0, $urandom_range(0, 400) == 0);
      end
      drain(70);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/trig_source_sched.md
Name: trig_source_sched

Overview:
Trigger source scheduler placed upstream of the APV trigger generator. It arbitrates three trigger sources: external, internal periodic and software. It enforces trigger pulse width, dead time and reset guard time. It drives the generator's TRIG_CMD/RESET_CMD level inputs and keeps accepted/rejected trigger statistics for the slow-control registers.

Parameters:
PULSE_W, 4, cycles TRIG_CMD/RESET_CMD are held high (legal range 2..15)
CNT_W, 32, width of statistics counters

Ports:
CLK  in  1  system clock
RSTb  in  1  reset; one clock, asynchronous, active-low
SRC_EN  in  3  source enables: bit0 external, bit1 periodic, bit2 software
EXT_TRIG  in  1  external trigger, asynchronous to CLK
SW_TRIG  in  1  one-cycle software trigger strobe
SW_RESET  in  1  one-cycle software request for an APV reset sequence
PERIOD  in  24  periodic source period in CLK cycles; 0 = periodic source off
DEAD_TIME  in  16  holdoff cycles after TRIG_CMD falls
RESET_GUARD  in  8  holdoff cycles after RESET_CMD falls
CLR_CNT  in  1  synchronous clear of statistics counters
TRIG_CMD  out  1  trigger command level to trigger generator
RESET_CMD  out  1  reset command level to trigger generator
BUSY  out  1  high when FSM not in IDLE
LAST_SRC  out  2  source of last accepted trigger: 0 ext, 1 periodic, 2 software
ACCEPTED_CNT  out  CNT_W  accepted triggers
REJECTED_CNT  out  CNT_W  rejected trigger requests

Behaviour:
- Reset (RSTb=0, asynchronous): all outputs 0, FSM to IDLE, all counters 0, reset-pending flag cleared. Asserting reset mid-operation truncates any pulse immediately.
- External path:
  - EXT_TRIG passes a 2-FF synchronizer, then a rising-edge detect register.
  - ext_req is a one-cycle pulse, 3 cycles after the EXT_TRIG rise.
- Periodic path:
  - Counter runs 0..PERIOD-1. per_req pulses in the cycle it equals PERIOD-1; the counter then wraps to 0.
  - Counter is held at 0 when PERIOD=0 or SRC_EN[1]=0.
  - If PERIOD is lowered below the current count, the counter fires on the next cycle and wraps.
- Qualification: ext_req&SRC_EN[0], per_req&SRC_EN[1], SW_TRIG&SRC_EN[2]. Disabled requests are ignored and not counted.
- SW_RESET is latched into a pending flag in any state. The flag is cleared on entry to RST.
- FSM, all outputs registered:
  - IDLE: if reset pending, go to RST; this has priority over triggers. Otherwise, if any qualified request is present, accept one with priority ext > periodic > software. On accept: LAST_SRC updated, ACCEPTED_CNT+1, go to TRIG. TRIG_CMD rises the cycle after the request.
  - TRIG: TRIG_CMD=1 for exactly PULSE_W cycles, then go to HOLD.
  - HOLD: TRIG_CMD=0 for max(DEAD_TIME,1) cycles (at least one low cycle so the generator sees an edge), then go to IDLE.
  - RST: RESET_CMD=1 for PULSE_W cycles, then go to RGUARD.
  - RGUARD: RESET_CMD=0 for max(RESET_GUARD,1) cycles, then go to IDLE.
  - Illegal state: go to IDLE.
- Rejection:
  - Every qualified request not accepted in a cycle adds 1 to REJECTED_CNT. This covers non-IDLE states, losers of same-cycle arbitration, and requests while a reset is pending.
  - Increment per cycle is 0..3. No request queuing.
- TRIGGER_DISABLED/space handling belongs to the trigger generator. Triggers are forwarded regardless, so the generator's missing-trigger count stays authoritative.
- Counters saturate at all-ones. CLR_CNT wins over a same-cycle increment.
- BUSY = (state != IDLE), registered together with the state.
- DEAD_TIME, RESET_GUARD and PERIOD are sampled live. A change during HOLD/RGUARD takes effect on the next comparison.

Optional Feature:
TRIG_TIMESTAMP_EN
- Defined: adds a 48-bit free-running TIMESTAMP counter (reset 0, wraps) and outputs TRIG_TIME[47:0] and TIME_VALID.
  - TRIG_TIME latches TIMESTAMP in the accept cycle.
  - TIME_VALID is a one-cycle strobe coincident with TRIG_CMD rising.
- Undefined: these ports and logic are absent; all other behaviour is identical.

Test Plan:
1. SRC_EN=010, PERIOD=100, DEAD_TIME=10, 1000 cycles -> 10 TRIG_CMD pulses, each 4 cycles wide, 100 cycles apart; ACCEPTED_CNT=10, REJECTED_CNT=0.
2. SRC_EN=111, ext_req and SW_TRIG in the same IDLE cycle -> one TRIG_CMD pulse, LAST_SRC=0, ACCEPTED_CNT=1, REJECTED_CNT=1.
3. SW_TRIG 2 cycles after TRIG_CMD falls, DEAD_TIME=10 -> no new pulse, REJECTED_CNT=1, BUSY high for 10 cycles after TRIG_CMD falls.
4. SW_RESET during TRIG, RESET_GUARD=20 -> trigger completes and HOLD completes, then RESET_CMD high 4 cycles, BUSY high 20 more cycles; a SW_TRIG at guard cycle 10 is rejected, and one after the guard is accepted.
5. EXT_TRIG rise at cycle t with SRC_EN=001 in IDLE -> TRIG_CMD high at cycles t+4..t+7. A second EXT_TRIG rise at t+3, before the first trigger's TRIG_CMD rises, is rejected (REJECTED_CNT=1).
6. RSTb low for 1 cycle mid-TRIG with counters at 5 -> TRIG_CMD 0 immediately, counters 0, BUSY 0. CLR_CNT in an accept cycle -> ACCEPTED_CNT=0.
